// File: rtl/spi_ram_pkg.sv
// Opcode encoding shared by the SPI RAM top, its memory array and the bench.
package spi_ram_pkg;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } opcode_t;

endpackage

// File: rtl/spi_ram_mem_array.sv
// Synchronous RAM with one write port and one registered read port.
// The read register only loads on a read, so it holds its last value between reads.
module spi_ram_mem_array
    import spi_ram_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Array contents are deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/spi_ram_param.sv
// Command decoder and read-latency pipeline for the SPI-slave memory.
// Read data is returned RD_LAT cycles after the command cycle, with a one-cycle tx_valid strobe.
module spi_ram_param
    import spi_ram_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int RD_LAT   = 1,
    parameter int AUTO_INC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [DATA_W+1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    output logic              rd_busy
);

    opcode_t           w_op;
    logic [DATA_W-1:0] w_payload;
    logic              w_wr;
    logic              w_rd;
    logic [DATA_W-1:0] w_rdata;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [RD_LAT-1:0] r_vld;

    assign w_op      = opcode_t'(din[DATA_W+1:DATA_W]);
    assign w_payload = din[DATA_W-1:0];
    assign w_wr      = rx_valid && (w_op == OP_WR_DATA);
    assign w_rd      = rx_valid && (w_op == OP_RD_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr <= '0;
            r_rd_addr <= '0;
        end else if (rx_valid) begin
            case (w_op)
                OP_WR_ADDR: r_wr_addr <= w_payload[ADDR_W-1:0];
                OP_WR_DATA: if (AUTO_INC != 0) r_wr_addr <= r_wr_addr + ADDR_W'(1);
                OP_RD_ADDR: r_rd_addr <= w_payload[ADDR_W-1:0];
                OP_RD_DATA: if (AUTO_INC != 0) r_rd_addr <= r_rd_addr + ADDR_W'(1);
                default:    ;
            endcase
        end
    end

    spi_ram_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_we    (w_wr),
        .i_waddr (r_wr_addr),
        .i_wdata (w_payload),
        .i_re    (w_rd),
        .i_raddr (r_rd_addr),
        .o_rdata (w_rdata)
    );

    // r_vld[k] marks valid data in stage k; stage 0 is the RAM read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_rd;
            for (int k = 1; k < RD_LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_direct
            assign dout = w_rdata;
        end else begin : g_pipe
            logic [DATA_W-1:0] r_pipe [1:RD_LAT-1];

            // Each stage loads only behind a valid entry, so dout holds between reads.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int k = 1; k < RD_LAT; k++) begin
                        r_pipe[k] <= '0;
                    end
                end else begin
                    if (r_vld[0]) begin
                        r_pipe[1] <= w_rdata;
                    end
                    for (int k = 2; k < RD_LAT; k++) begin
                        if (r_vld[k-1]) begin
                            r_pipe[k] <= r_pipe[k-1];
                        end
                    end
                end
            end

            assign dout = r_pipe[RD_LAT-1];
        end
    endgenerate

    assign tx_valid = r_vld[RD_LAT-1];
    assign rd_busy  = |r_vld;

endmodule

// File: tb/tb_spi_ram_param.sv
// Bench for spi_ram_param: three parameterisations driven side by side, checked against a read scoreboard.
module tb_spi_ram_param;
    import spi_ram_pkg::*;

    typedef struct {
        logic [15:0] data;
        int          cmd_cyc;
        int          exp_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ab, rst_c;
    logic        rxv_a, rxv_b, rxv_c;
    logic [9:0]  din_a, din_b;
    logic [17:0] din_c;
    logic [7:0]  dout_a, dout_b;
    logic [15:0] dout_c;
    logic        tx_a, tx_b, tx_c;
    logic        busy_a, busy_b, busy_c;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_ram_param #(.DATA_W(8), .ADDR_W(8), .RD_LAT(1), .AUTO_INC(0)) u_dut_a (
        .clk(clk), .rst_n(rst_ab), .rx_valid(rxv_a), .din(din_a),
        .dout(dout_a), .tx_valid(tx_a), .rd_busy(busy_a));

    spi_ram_param #(.DATA_W(8), .ADDR_W(8), .RD_LAT(2), .AUTO_INC(1)) u_dut_b (
        .clk(clk), .rst_n(rst_ab), .rx_valid(rxv_b), .din(din_b),
        .dout(dout_b), .tx_valid(tx_b), .rd_busy(busy_b));

    spi_ram_param #(.DATA_W(16), .ADDR_W(4), .RD_LAT(3), .AUTO_INC(0)) u_dut_c (
        .clk(clk), .rst_n(rst_c), .rx_valid(rxv_c), .din(din_c),
        .dout(dout_c), .tx_valid(tx_c), .rd_busy(busy_c));

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int lat_of(int d);
        return (d == 0) ? 1 : (d == 1) ? 2 : 3;
    endfunction

    // Called at posedge+1; returns at the following posedge+1.
    task automatic cmd(int d, logic [1:0] op, logic [15:0] pl);
        case (d)
            0:       begin rxv_a = 1'b1; din_a = {op, pl[7:0]}; end
            1:       begin rxv_b = 1'b1; din_b = {op, pl[7:0]}; end
            default: begin rxv_c = 1'b1; din_c = {op, pl}; end
        endcase
        @(posedge clk);
        #1;
        rxv_a = 1'b0;
        rxv_b = 1'b0;
        rxv_c = 1'b0;
    endtask

    task automatic rd(int d, logic [15:0] exp_d);
        exp_t e;
        e.data    = exp_d;
        e.cmd_cyc = cyc;
        e.exp_cyc = cyc + lat_of(d);
        sb_q[d].push_back(e);
        cmd(d, OP_RD_DATA, 16'($urandom));
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mon(int d, logic tx, logic [15:0] dq, logic busy);
        exp_t e;
        logic pend;
        e    = '{data: 16'h0, cmd_cyc: 0, exp_cyc: 0};
        pend = (sb_q[d].size() > 0);
        if (pend) e = sb_q[d][0];
        check($sformatf("busy_%0d", d), {31'b0, busy}, {31'b0, pend && (e.cmd_cyc < cyc)});
        if (tx) begin
            if (!pend) begin
                check($sformatf("spurious_tx_%0d", d), {31'b0, tx}, 32'd0);
            end else begin
                check($sformatf("rd_data_%0d", d), {16'b0, dq}, {16'b0, e.data});
                check($sformatf("rd_lat_%0d", d), cyc, e.exp_cyc);
                void'(sb_q[d].pop_front());
            end
        end else if (pend && (e.exp_cyc <= cyc)) begin
            check($sformatf("missed_tx_%0d", d), {31'b0, tx}, 32'd1);
            void'(sb_q[d].pop_front());
        end
    endtask

    always @(negedge clk) begin
        mon(0, tx_a, {8'h00, dout_a}, busy_a);
        mon(1, tx_b, {8'h00, dout_b}, busy_b);
        mon(2, tx_c, dout_c, busy_c);
    end

    initial begin
        rst_ab = 1'b0;
        rst_c  = 1'b0;
        rxv_a  = 1'b0;
        rxv_b  = 1'b0;
        rxv_c  = 1'b0;
        din_a  = '0;
        din_b  = '0;
        din_c  = '0;
        idle(3);
        rst_ab = 1'b1;
        rst_c  = 1'b1;

        for (int i = 0; i < 10; i++) begin
            check("idle_dout", {24'b0, dout_a}, 32'h0);
            check("idle_tx", {31'b0, tx_a}, 32'h0);
            check("idle_busy", {31'b0, busy_a}, 32'h0);
            idle(1);
        end

        // Default parameters: basic write/read and address independence
        cmd(0, OP_WR_ADDR, 16'h0012);
        cmd(0, OP_WR_DATA, 16'h00A5);
        cmd(0, OP_RD_ADDR, 16'h0012);
        rd(0, 16'h00A5);
        cmd(0, OP_WR_ADDR, 16'h0034);
        cmd(0, OP_WR_DATA, 16'h003C);
        cmd(0, OP_RD_ADDR, 16'h0012);
        rd(0, 16'h00A5);
        cmd(0, OP_RD_ADDR, 16'h0034);
        rd(0, 16'h003C);
        rd(0, 16'h003C);
        idle(4);
        check("a_dout_hold", {24'b0, dout_a}, 32'h3C);

        // AUTO_INC, RD_LAT=2: burst across the address wrap
        cmd(1, OP_WR_ADDR, 16'h00FE);
        cmd(1, OP_WR_DATA, 16'h0011);
        cmd(1, OP_WR_DATA, 16'h0022);
        cmd(1, OP_WR_DATA, 16'h0033);
        cmd(1, OP_RD_ADDR, 16'h00FE);
        rd(1, 16'h0011);
        rd(1, 16'h0022);
        rd(1, 16'h0033);
        cmd(1, OP_WR_DATA, 16'h0044);
        idle(3);
        check("b_dout_hold", {24'b0, dout_b}, 32'h33);

        // Read opcode without rx_valid must do nothing
        din_b = {OP_RD_DATA, 8'h00};
        idle(5);
        rd(1, 16'h0044);
        cmd(1, OP_WR_DATA, 16'h0055);
        rd(1, 16'h0055);
        // Address change right behind a read must not disturb it
        cmd(1, OP_RD_ADDR, 16'h00FE);
        rd(1, 16'h0011);
        cmd(1, OP_RD_ADDR, 16'h0001);
        idle(4);

        // DATA_W=16, ADDR_W=4, RD_LAT=3: upper address bits ignored
        cmd(2, OP_WR_ADDR, 16'h0000);
        cmd(2, OP_WR_DATA, 16'h1234);
        cmd(2, OP_WR_ADDR, 16'hFFF5);
        cmd(2, OP_WR_DATA, 16'hBEEF);
        cmd(2, OP_RD_ADDR, 16'h0005);
        rd(2, 16'hBEEF);
        idle(5);
        check("c_dout_hold", {16'b0, dout_c}, 32'hBEEF);

        // Reset while a read is in flight
        cmd(2, OP_RD_DATA, 16'h0000);
        check("c_busy_inflight", {31'b0, busy_c}, 32'h1);
        rst_c = 1'b0;
        sb_q[2].delete();
        #1;
        check("c_busy_rst", {31'b0, busy_c}, 32'h0);
        check("c_tx_rst", {31'b0, tx_c}, 32'h0);
        check("c_dout_rst", {16'b0, dout_c}, 32'h0);
        idle(2);
        rst_c = 1'b1;
        idle(6);
        rd(2, 16'h1234);
        idle(4);
        cmd(2, OP_WR_DATA, 16'h7777);
        cmd(2, OP_RD_ADDR, 16'h0000);
        rd(2, 16'h7777);
        idle(8);

        check("sb_empty_a", sb_q[0].size(), 32'd0);
        check("sb_empty_b", sb_q[1].size(), 32'd0);
        check("sb_empty_c", sb_q[2].size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
